// File: rtl/dfi_diram_channel_if.sv
// DFI command/write-data path from a manager plus the PHY read-return path.
interface dfi_diram_channel_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2
);
  logic              dfi__phy__cs;
  logic              dfi__phy__cmd1;
  logic              dfi__phy__cmd0;
  logic [ADDR_W-1:0] dfi__phy__addr;
  logic [BANK_W-1:0] dfi__phy__bank;
  logic [DATA_W-1:0] dfi__phy__data;
  logic              phy__dfi__valid;
  logic [DATA_W-1:0] phy__dfi__data;

  modport master (
    output dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0,
           dfi__phy__addr, dfi__phy__bank, dfi__phy__data,
    input  phy__dfi__valid, phy__dfi__data
  );

  modport slave (
    input  dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0,
           dfi__phy__addr, dfi__phy__bank, dfi__phy__data,
    output phy__dfi__valid, phy__dfi__data
  );
endinterface

// File: rtl/dfi_diram_channel.sv
// Single-channel DiRAM responder: per-bank row/tRCD tracking, storage array,
// fixed-latency read return and protocol-violation accounting.
module dfi_diram_channel #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 13,
  parameter int BANK_W   = 2,
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 5,
  parameter int TRCD     = 2,
  parameter int RD_LAT   = 4
) (
  input  logic                    clk,
  input  logic                    reset_poweron,
  dfi_diram_channel_if.slave      dfi,
  output logic                    err_sticky,
  output logic [7:0]              err_count,
  output logic [(1<<BANK_W)-1:0]  bank_open
);
  localparam int NUM_BANKS = 1 << BANK_W;
  localparam int IDX_W     = BANK_W + ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << IDX_W;

  logic [ROW_BITS-1:0] row_q  [NUM_BANKS];
  logic [3:0]          trcd_q [NUM_BANKS];
  logic [DATA_W-1:0]   mem    [DEPTH];
  logic [RD_LAT-1:0]   vpipe_q;
  logic [DATA_W-1:0]   dpipe_q [RD_LAT];

  logic is_pre, is_act, is_rd, is_wr;
  logic sel_open, sel_ready, viol;
  logic acc_act, acc_pre, acc_rd, acc_wr;
  logic [IDX_W-1:0] idx;
  logic unused_addr_bits;

  assign is_pre = dfi.dfi__phy__cs && !dfi.dfi__phy__cmd1 && !dfi.dfi__phy__cmd0;
  assign is_act = dfi.dfi__phy__cs && !dfi.dfi__phy__cmd1 &&  dfi.dfi__phy__cmd0;
  assign is_rd  = dfi.dfi__phy__cs &&  dfi.dfi__phy__cmd1 && !dfi.dfi__phy__cmd0;
  assign is_wr  = dfi.dfi__phy__cs &&  dfi.dfi__phy__cmd1 &&  dfi.dfi__phy__cmd0;

  assign sel_open  = bank_open[dfi.dfi__phy__bank];
  assign sel_ready = sel_open && (trcd_q[dfi.dfi__phy__bank] == 4'd0);

  assign acc_pre = is_pre;
  assign acc_act = is_act && !sel_open;
  assign acc_rd  = is_rd && sel_ready;
  assign acc_wr  = is_wr && sel_ready;
  assign viol    = (is_act && sel_open) || ((is_rd || is_wr) && !sel_ready);

  assign idx = {dfi.dfi__phy__bank, row_q[dfi.dfi__phy__bank],
                dfi.dfi__phy__addr[COL_BITS-1:0]};
  assign unused_addr_bits = ^dfi.dfi__phy__addr[ADDR_W-1:COL_BITS];

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      bank_open <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        row_q[b]  <= '0;
        trcd_q[b] <= 4'd0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (trcd_q[b] != 4'd0) trcd_q[b] <= trcd_q[b] - 4'd1;
        if (dfi.dfi__phy__bank == BANK_W'(b)) begin
          if (acc_pre) bank_open[b] <= 1'b0;
          if (acc_act) begin
            bank_open[b] <= 1'b1;
            row_q[b]     <= dfi.dfi__phy__addr[ROW_BITS-1:0];
            trcd_q[b]    <= 4'(TRCD - 1);
          end
        end
      end
    end
  end

  // Storage is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (acc_wr) mem[idx] <= dfi.dfi__phy__data;
  end

  // Stage 0 captures at the RD edge, the output register adds the final cycle.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      vpipe_q             <= '0;
      dfi.phy__dfi__valid <= 1'b0;
      dfi.phy__dfi__data  <= '0;
      for (int s = 0; s < RD_LAT; s++) dpipe_q[s] <= '0;
    end else begin
      vpipe_q[0] <= acc_rd;
      dpipe_q[0] <= acc_rd ? mem[idx] : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        vpipe_q[s] <= vpipe_q[s-1];
        dpipe_q[s] <= dpipe_q[s-1];
      end
      dfi.phy__dfi__valid <= vpipe_q[RD_LAT-1];
      dfi.phy__dfi__data  <= dpipe_q[RD_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      err_sticky <= 1'b0;
      err_count  <= 8'd0;
    end else if (viol) begin
      err_sticky <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_dfi_diram_channel.sv
// Scoreboard bench for dfi_diram_channel: a behavioural bank/memory model
// predicts read returns and violation counts.
module tb_dfi_diram_channel;
  localparam int DATA_W = 64;
  localparam int TRCD   = 2;
  localparam int RD_LAT = 4;

  localparam int PRE = 0, ACT = 1, RD = 2, WR = 3;

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_poweron;
  logic       err_sticky;
  logic [7:0] err_count;
  logic [3:0] bank_open;

  dfi_diram_channel_if #(.DATA_W(64), .ADDR_W(13), .BANK_W(2)) dif ();

  dfi_diram_channel dut (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .dfi           (dif.slave),
    .err_sticky    (err_sticky),
    .err_count     (err_count),
    .bank_open     (bank_open)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  exp_t sb[$];

  bit          m_open [4];
  int          m_row  [4];
  int          m_act  [4];
  logic [63:0] ref_mem [int];
  int          exp_err;
  bit          exp_sticky;

  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // Read-return monitor: every valid must match the oldest outstanding read on its due cycle.
  always @(negedge clk) begin
    if (dif.phy__dfi__valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rd_latency", edge_cnt, e.due);
        checkOutput("rd_data", dif.phy__dfi__data, e.data);
      end
    end else if (sb.size() != 0 && sb[0].due <= edge_cnt) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("missing_valid", edge_cnt, e.due + 1000);
    end
  end

  function automatic void modelReset();
    for (int b = 0; b < 4; b++) begin
      m_open[b] = 0;
      m_row[b]  = 0;
      m_act[b]  = -100;
    end
    exp_err    = 0;
    exp_sticky = 0;
  endfunction

  function automatic void modelViol();
    exp_sticky = 1;
    if (exp_err < 255) exp_err++;
  endfunction

  task automatic applyStimulus(input int cmd, input int bank, input int addr, input logic [63:0] data);
    int e, idx;
    e = edge_cnt + 1;
    dif.dfi__phy__cs   = 1'b1;
    dif.dfi__phy__cmd1 = cmd[1];
    dif.dfi__phy__cmd0 = cmd[0];
    dif.dfi__phy__bank = bank[1:0];
    dif.dfi__phy__addr = addr[12:0];
    dif.dfi__phy__data = data;
    idx = bank * 128 + m_row[bank] * 32 + (addr % 32);
    case (cmd)
      PRE: m_open[bank] = 0;
      ACT: begin
        if (m_open[bank]) modelViol();
        else begin
          m_open[bank] = 1;
          m_row[bank]  = addr % 4;
          m_act[bank]  = e;
        end
      end
      default: begin
        if (!m_open[bank] || e < m_act[bank] + TRCD) modelViol();
        else if (cmd == WR) ref_mem[idx] = data;
        else begin
          exp_t x;
          x.due  = e + RD_LAT;
          x.data = ref_mem.exists(idx) ? ref_mem[idx] : 64'hx;
          sb.push_back(x);
        end
      end
    endcase
    @(posedge clk);
    #1 dif.dfi__phy__cs = 1'b0;
    @(negedge clk);
    checkOutput("err_count", err_count, exp_err);
    checkOutput("err_sticky", err_sticky, exp_sticky);
    checkOutput("bank_open", bank_open, {m_open[3], m_open[2], m_open[1], m_open[0]});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, dif.phy__dfi__valid, 0);
    checkOutput({tag, "_data"}, dif.phy__dfi__data, 0);
    checkOutput({tag, "_sticky"}, err_sticky, 0);
    checkOutput({tag, "_count"}, err_count, 0);
    checkOutput({tag, "_bank_open"}, bank_open, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_poweron      = 1'b0;
    dif.dfi__phy__cs   = 1'b0;
    dif.dfi__phy__cmd1 = 1'b0;
    dif.dfi__phy__cmd0 = 1'b0;
    dif.dfi__phy__addr = '0;
    dif.dfi__phy__bank = '0;
    dif.dfi__phy__data = '0;
    modelReset();
    idle(2);
    checkResetOutputs("por");
    reset_poweron = 1'b1;
    idle(1);

    // Basic write then read with latency check.
    applyStimulus(ACT, 0, 1, 0);
    idle(1);
    applyStimulus(WR, 0, 3, 64'hDEADBEEF_00000001);
    applyStimulus(RD, 0, 3, 0);
    drain();

    // tRCD violation then a legal read on bank 1.
    applyStimulus(ACT, 1, 2, 0);
    idle(1);
    applyStimulus(WR, 1, 5, 64'h1111_2222_3333_4444);
    applyStimulus(PRE, 1, 0, 0);
    applyStimulus(ACT, 1, 2, 0);
    applyStimulus(RD, 1, 5, 0);
    applyStimulus(RD, 1, 5, 0);
    drain();

    // All four banks, then eight back-to-back interleaved reads.
    applyStimulus(ACT, 2, 3, 0);
    applyStimulus(ACT, 3, 0, 0);
    idle(1);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(WR, b, 7, 64'hA000_0000_0000_0700 + 64'(b));
      applyStimulus(WR, b, 8, 64'hB000_0000_0000_0800 + 64'(b));
    end
    for (int k = 0; k < 8; k++)
      applyStimulus(RD, (k < 4) ? k : 7 - k, (k < 4) ? 7 : 8, 0);
    drain();

    // Dropped write to a closed bank keeps old contents; ACT to open bank rejected.
    applyStimulus(PRE, 2, 0, 0);
    applyStimulus(WR, 2, 7, 64'hBAD0_BAD0_BAD0_BAD0);
    applyStimulus(ACT, 2, 3, 0);
    idle(1);
    applyStimulus(RD, 2, 7, 0);
    applyStimulus(ACT, 0, 2, 0);
    drain();

    // Saturation of the violation counter.
    applyStimulus(PRE, 3, 0, 0);
    for (int i = 0; i < 300; i++) applyStimulus(RD, 3, 7, 0);
    checkOutput("sat_count", err_count, 255);

    // Reset with reads in flight: they must never return.
    applyStimulus(ACT, 3, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) applyStimulus(RD, 3, 7 + (i % 2), 0);
    reset_poweron = 1'b0;
    sb.delete();
    modelReset();
    @(negedge clk);
    checkResetOutputs("midrst");
    reset_poweron = 1'b1;
    idle(RD_LAT + 4);
    checkOutput("post_rst_bank_open", bank_open, 0);
    checkOutput("post_rst_count", err_count, 0);

    // Storage survives reset; re-open and read back.
    applyStimulus(ACT, 0, 1, 0);
    idle(1);
    applyStimulus(RD, 0, 3, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dfi_diram_channel.md
# dfi_diram_channel

Single-channel DiRAM responder that terminates one manager's DFI command/data interface. It sits directly downstream of each manager in the manager array and consumes the manager's DFI command stream (cs, cmd1/cmd0, addr, bank, write data). It tracks per-bank open rows and activate-to-access timing, stores write data in an internal array, and returns read data on the `phy__dfi__*` return path after a fixed latency. Protocol violations are flagged and counted.

## Interface
Parameters:
- DATA_W, 64, width of dfi__phy__data / phy__dfi__data
- ADDR_W, 13, width of dfi__phy__addr (row on ACT, column on RD/WR)
- BANK_W, 2, width of dfi__phy__bank; NUM_BANKS = 2^BANK_W
- ROW_BITS, 2, row LSBs retained in storage index
- COL_BITS, 5, column LSBs retained in storage index
- TRCD, 2, minimum cycles from ACT to RD/WR on the same bank (1..15)
- RD_LAT, 4, cycles from accepted RD to phy__dfi__valid (2..16)

Ports:
- clk  in  1  single clock; everything is sampled on the rising edge
- reset_poweron  in  1  asynchronous, active-low reset
- dfi__phy__cs  in  1  command strobe, active-high; 0 = NOP
- dfi__phy__cmd1  in  1  command bit 1
- dfi__phy__cmd0  in  1  command bit 0
- dfi__phy__addr  in  ADDR_W  row (ACT) or column (RD/WR)
- dfi__phy__bank  in  BANK_W  target bank
- dfi__phy__data  in  DATA_W  write data, valid in the WR command cycle
- phy__dfi__valid  out  1  read data valid, one cycle per accepted RD
- phy__dfi__data  out  DATA_W  read data
- err_sticky  out  1  set on first violation; cleared only by reset
- err_count  out  8  violation count, saturates at 255
- bank_open  out  NUM_BANKS  per-bank open-row flags

## Operation
- Command = {cmd1,cmd0}, qualified by cs: 00 PRE, 01 ACT, 10 RD, 11 WR.
- Per-bank state: open flag, open_row[ROW_BITS-1:0], trcd_cnt (4-bit).
- PRE: clears the open flag. PRE to a closed bank is a legal no-op.
- ACT to a closed bank: sets the open flag, latches row LSBs, and loads trcd_cnt = TRCD-1.
- ACT to an open bank: violation. The command is dropped and the row is unchanged.
- trcd_cnt decrements each cycle while nonzero.
- RD/WR are legal only when the bank is open and trcd_cnt == 0.
- RD/WR to a closed bank, or with trcd_cnt != 0, is a violation. The command is dropped; no valid is produced and no memory write occurs.
- Storage index = {bank, open_row[ROW_BITS-1:0], addr[COL_BITS-1:0]}. Depth is NUM_BANKS·2^ROW_BITS·2^COL_BITS (512 at defaults).
- WR: the memory location is updated at the command edge.
- RD: the memory is read at the command edge; data enters an RD_LAT-deep valid/data shift pipeline.
- Read-after-write: an RD issued in a cycle after a WR to the same index returns the new data.
- Violations: err_sticky is set and err_count increments by 1, saturating at 255. At most one violation is counted per cycle.

## Timing
- Reset asserted (reset_poweron = 0), outputs: phy__dfi__valid = 0, phy__dfi__data = 0, err_sticky = 0, err_count = 0, bank_open = 0.
- Reset asserted, internal state: all trcd_cnt = 0 and the pipeline is flushed. Storage contents are not reset.
- Reset mid-operation: in-flight reads are discarded; no valid appears after release.
- First command is accepted on the first rising edge after reset deasserts.
- RD accepted at edge n gives phy__dfi__valid = 1 with data during cycle n+RD_LAT.
- Back-to-back RDs on consecutive cycles give valid high on consecutive cycles, in order. There is no backpressure.
- ACT at edge n: the earliest legal RD/WR on that bank is at edge n+TRCD. Other banks are unaffected.
- bank_open updates at the command edge and is visible in the following cycle.
- All outputs are registered.

## Test plan
- Reset, then ACT b0 row 1, wait 2, WR b0 col 3 = 0xDEADBEEF_00000001, RD b0 col 3 at edge n -> valid only at n+4, data 0xDEADBEEF_00000001, err_count 0.
- ACT b1, then RD b1 one cycle later (TRCD violation) -> no valid, err_sticky 1, err_count 1; RD at ACT+2 -> valid with stored data.
- WR to all 4 banks at different rows, then 8 back-to-back RDs interleaving banks -> 8 consecutive valid cycles with data in issue order.
- PRE b2, then WR b2 -> dropped, err_count +1; a subsequent ACT b2, RD returns the pre-drop contents; ACT b0 while open -> err +1, bank_open[0] stays 1.
- 300 violations -> err_count saturates at 255; err_sticky stays 1.
- Issue 3 RDs, assert reset_poweron = 0 for one cycle between issue and return -> no valid ever; all outputs 0 during reset; bank_open 0 after reset.
